// File: rtl/fx68k_pkg.sv
// Shared types for the fx68k prefetch queue: queue entry layout and fetch FSM states.
package fx68k_pkg;

    typedef struct packed {
        logic        berr;
        logic [15:0] data;
    } s_pfq_entry;

    localparam int PFQ_MAX_DEPTH = 8;

    typedef enum logic [1:0] {
        PFQ_IDLE,
        PFQ_REQ,
        PFQ_DROP
    } e_pfq_fetch;

endpackage

// File: rtl/fx68k_pfq_fetch.sv
// Prefetch fetch controller: one outstanding word request, address incrementer, flush drop.
// Latency: request issued 1 enabled cycle after space appears; chains straight into the next request on ack.
// Backpressure: no request is issued unless the top reports a reserved free slot (i_fetch_ok).
module fx68k_pfq_fetch
    import fx68k_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              extReset,
    input  logic              enPhi2,
    input  logic              i_pcLoad,
    input  logic [ADDR_W-1:0] i_pcLoadAddr,
    input  logic              i_fetch_ok,
    input  logic              i_busAck,
    input  logic              i_busErr,
    output logic              o_fetchReq,
    output logic [ADDR_W-1:0] o_fetchAddr,
    output logic              o_push
);

    e_pfq_fetch        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              w_resp;
    logic [ADDR_W-1:0] w_load_addr;

    assign w_resp      = i_busAck || i_busErr;
    assign w_load_addr = i_pcLoadAddr & ~ADDR_W'(1);
    assign o_fetchReq  = (r_state == PFQ_REQ);
    assign o_fetchAddr = r_addr;
    assign o_push      = (r_state == PFQ_REQ) && w_resp && !i_pcLoad;

    always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
            r_state <= PFQ_IDLE;
            r_addr  <= '0;
        end else if (enPhi2) begin
            case (r_state)
                PFQ_IDLE: begin
                    if (i_pcLoad)
                        r_addr <= w_load_addr;
                    else if (i_fetch_ok)
                        r_state <= PFQ_REQ;
                end
                PFQ_REQ: begin
                    if (i_pcLoad) begin
                        // A response landing with the flush is simply dropped.
                        r_addr  <= w_load_addr;
                        r_state <= w_resp ? PFQ_IDLE : PFQ_DROP;
                    end else if (w_resp) begin
                        r_addr  <= r_addr + ADDR_W'(2);
                        r_state <= i_fetch_ok ? PFQ_REQ : PFQ_IDLE;
                    end
                end
                PFQ_DROP: begin
                    if (i_pcLoad)
                        r_addr <= w_load_addr;
                    if (w_resp)
                        r_state <= PFQ_IDLE;
                end
                default: r_state <= PFQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fx68k_prefetch_queue.sv
// DEPTH-word instruction prefetch FIFO with per-word bus-error flag; loop replay with FX68K_PFQ_LOOP_EN.
// Latency: first-word fall-through, head visible 1 enabled cycle after busAck.
// Backpressure: fetches stop when count plus the in-flight word would exceed DEPTH; pop on empty is ignored.
module fx68k_prefetch_queue
    import fx68k_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 24
) (
    input  logic                       clk,
    input  logic                       extReset,
    input  logic                       enPhi2,
    input  logic                       pcLoad,
    input  logic [ADDR_W-1:0]          pcLoadAddr,
    output logic                       fetchReq,
    output logic [ADDR_W-1:0]          fetchAddr,
    input  logic                       busAck,
    input  logic                       busErr,
    input  logic [15:0]                busData,
    input  logic                       pop,
    output logic                       popValid,
    output logic [15:0]                popWord,
    output logic                       popBerr,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FX68K_PFQ_LOOP_EN
    ,
    input  logic                       loopStart,
    input  logic                       loopExit,
    input  logic [2:0]                 loopLen,
    output logic                       loopActive,
    output logic                       loopErr
`endif
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   L_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] L_LAST  = PW'(DEPTH - 1);

    s_pfq_entry    r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    s_pfq_entry    w_head;
    logic          w_push;
    logic          w_pop_eff;
    logic          w_pop_dec;
    logic          w_pop_blk;
    logic          w_loop_hold;
    logic          w_fetch_ok;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == L_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef FX68K_PFQ_LOOP_EN
    logic          r_loop_act;
    logic          r_loop_err;
    logic [PW-1:0] r_base;
    logic [2:0]    r_len;
    logic [2:0]    r_lcnt;
    logic          w_loop_go;
    logic          w_loop_exit;
    logic [3:0]    w_sum;
    logic [PW-1:0] w_rd_exit;

    assign w_loop_go   = loopStart && !r_loop_act && (loopLen != 3'd0)
                         && ({1'b0, loopLen} <= 4'(r_count));
    assign w_loop_exit = r_loop_act && loopExit;
    assign w_pop_blk   = w_loop_go || w_loop_exit;
    assign w_loop_hold = r_loop_act;
    assign w_pop_dec   = w_pop_eff && !r_loop_act;
    assign w_sum       = 4'(r_base) + {1'b0, r_len};
    assign w_rd_exit   = (w_sum >= 4'(DEPTH)) ? PW'(w_sum - 4'(DEPTH)) : PW'(w_sum);
    assign loopActive  = r_loop_act;
    assign loopErr     = r_loop_err;
`else
    assign w_pop_blk   = 1'b0;
    assign w_loop_hold = 1'b0;
    assign w_pop_dec   = w_pop_eff;
`endif

    assign w_head    = r_mem[r_rd];
    assign popValid  = (r_count != '0);
    assign popWord   = popValid ? w_head.data : 16'h0000;
    assign popBerr   = popValid && w_head.berr;
    assign count     = r_count;
    assign w_pop_eff = pop && popValid && !pcLoad && !w_pop_blk;
    // A pop in this cycle frees a slot the next request may claim.
    assign w_fetch_ok = !w_loop_hold
                        && (({1'b0, r_count} + (CW + 1)'(w_push)) < (L_DEPTH + (CW + 1)'(w_pop_dec)));

    fx68k_pfq_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk          (clk),
        .extReset     (extReset),
        .enPhi2       (enPhi2),
        .i_pcLoad     (pcLoad),
        .i_pcLoadAddr (pcLoadAddr),
        .i_fetch_ok   (w_fetch_ok),
        .i_busAck     (busAck),
        .i_busErr     (busErr),
        .o_fetchReq   (fetchReq),
        .o_fetchAddr  (fetchAddr),
        .o_push       (w_push)
    );

    always_ff @(posedge clk) begin
        if (enPhi2 && w_push)
            r_mem[r_wr] <= '{berr: busErr, data: busData};
    end

    always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
`ifdef FX68K_PFQ_LOOP_EN
            r_loop_act <= 1'b0;
            r_loop_err <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_lcnt     <= '0;
`endif
        end else if (enPhi2) begin
            if (pcLoad) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
`ifdef FX68K_PFQ_LOOP_EN
                r_loop_act <= 1'b0;
                r_loop_err <= 1'b0;
                r_lcnt     <= '0;
`endif
            end else begin
                if (w_push)
                    r_wr <= f_inc(r_wr);
`ifdef FX68K_PFQ_LOOP_EN
                r_loop_err <= loopStart && !r_loop_act && !w_loop_go;
                if (w_loop_exit) begin
                    // Resume normal flow just past the loop body.
                    r_loop_act <= 1'b0;
                    r_rd       <= w_rd_exit;
                    r_count    <= r_count - CW'(r_len) + CW'(w_push);
                end else begin
                    if (w_loop_go) begin
                        r_loop_act <= 1'b1;
                        r_base     <= r_rd;
                        r_len      <= loopLen;
                        r_lcnt     <= '0;
                    end
                    if (w_pop_eff) begin
                        if (!r_loop_act) begin
                            r_rd <= f_inc(r_rd);
                        end else if (r_lcnt == r_len - 3'd1) begin
                            r_rd   <= r_base;
                            r_lcnt <= '0;
                        end else begin
                            r_rd   <= f_inc(r_rd);
                            r_lcnt <= r_lcnt + 3'd1;
                        end
                    end
                    r_count <= r_count + CW'(w_push) - CW'(w_pop_dec);
                end
`else
                if (w_pop_eff)
                    r_rd <= f_inc(r_rd);
                r_count <= r_count + CW'(w_push) - CW'(w_pop_dec);
`endif
            end
        end
    end

endmodule
